// File: rtl/axi_slave_bridge_pkg.sv
// Shared encodings for the AXI slave bridge: burst types, FSM states and the
// byte-count helper used when a command is popped from the slave command FIFO.
package axi_slave_bridge_pkg;

  localparam int CHUNK_LOG2_DEF = 7;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } split_state_e;

  // Bytes from the start address to the end of an INCR burst. Only the low
  // address bits within one beat matter; the result peaks at 32768.
  function automatic logic [15:0] burst_bytes(input logic [6:0] addr_lo,
                                              input logic [7:0] len,
                                              input logic [2:0] size);
    logic [15:0] off;
    off = {9'd0, addr_lo} & ((16'd1 << size) - 16'd1);
    return ((16'(len) + 16'd1) << size) - off;
  endfunction

endpackage

// File: rtl/axi_slave_cmd_splitter_if.sv
// Command FIFO head plus piece handshake between the FIFO, the splitter and
// the host-link command encoder.
interface axi_slave_cmd_splitter_if #(
  parameter int IDW        = 3,
  parameter int CTXW       = 9,
  parameter int CHUNK_LOG2 = 7
);
  logic [IDW-1:0]      cf_id;
  logic [63:0]         cf_addr;
  logic [7:0]          cf_len;
  logic [2:0]          cf_size;
  logic [1:0]          cf_burst;
  logic [CTXW-1:0]     cf_user;
  logic                cf_empty;
  logic                cf_rd_en;
  logic                sp_valid;
  logic                sp_ready;
  logic [IDW-1:0]      sp_id;
  logic [63:0]         sp_addr;
  logic [CHUNK_LOG2:0] sp_bytes;
  logic [CTXW-1:0]     sp_user;
  logic                sp_first;
  logic                sp_last;
  logic                sp_err;

  // The splitter pulls from the FIFO and drives pieces downstream.
  modport master (
    input  cf_id, cf_addr, cf_len, cf_size, cf_burst, cf_user, cf_empty, sp_ready,
    output cf_rd_en, sp_valid, sp_id, sp_addr, sp_bytes, sp_user, sp_first, sp_last, sp_err
  );

  modport slave (
    output cf_id, cf_addr, cf_len, cf_size, cf_burst, cf_user, cf_empty, sp_ready,
    input  cf_rd_en, sp_valid, sp_id, sp_addr, sp_bytes, sp_user, sp_first, sp_last, sp_err
  );
endinterface

// File: rtl/axi_slave_split_calc.sv
// Size of the next piece: the smaller of the bytes remaining and the room left
// before the next CHUNK_BYTES boundary. Shared with the write-data aligner.
module axi_slave_split_calc
  import axi_slave_bridge_pkg::*;
#(
  parameter int CHUNK_LOG2 = CHUNK_LOG2_DEF
) (
  input  logic [CHUNK_LOG2-1:0] cur_lo,
  input  logic [15:0]           rem,
  output logic [CHUNK_LOG2:0]   bytes,
  output logic                  last
);
  localparam logic [CHUNK_LOG2:0] CHUNK_BYTES = {1'b1, {CHUNK_LOG2{1'b0}}};

  logic [CHUNK_LOG2:0] room;

  always_comb begin
    room  = CHUNK_BYTES - {1'b0, cur_lo};
    last  = (rem <= 16'(room));
    bytes = last ? rem[CHUNK_LOG2:0] : room;
  end
endmodule

// File: rtl/axi_slave_cmd_splitter.sv
// Pops AXI bursts from the slave command FIFO and issues chunk-aligned pieces.
// Define AXI_SLAVE_SPLITTER_STATS_EN to add burst/piece counters.
module axi_slave_cmd_splitter
  import axi_slave_bridge_pkg::*;
#(
  parameter int IDW        = 3,
  parameter int CTXW       = 9,
  parameter int CHUNK_LOG2 = CHUNK_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_slave_cmd_splitter_if.master bus
`ifdef AXI_SLAVE_SPLITTER_STATS_EN
  ,
  output logic [31:0]           stat_bursts,
  output logic [31:0]           stat_pieces
`endif
);
  split_state_e      state_q, state_d;
  logic [63:0]       cur_q, cur_d;
  logic [15:0]       rem_q, rem_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [CTXW-1:0]   user_q, user_d;
  logic              first_q, first_d;
  logic              err_q, err_d;

  logic [CHUNK_LOG2:0] calc_bytes;
  logic                calc_last;
  logic                issue, hs, pop;

  axi_slave_split_calc #(.CHUNK_LOG2(CHUNK_LOG2)) u_calc (
    .cur_lo (cur_q[CHUNK_LOG2-1:0]),
    .rem    (rem_q),
    .bytes  (calc_bytes),
    .last   (calc_last)
  );

  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      id_q    <= '0;
      user_q  <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      user_q  <= user_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    id_d    = id_q;
    user_d  = user_q;
    first_d = first_q;
    err_d   = err_q;
    if (hs && !calc_last) begin
      cur_d   = cur_q + 64'(calc_bytes);
      rem_d   = rem_q - 16'(calc_bytes);
      first_d = 1'b0;
    end else if (hs) begin
      state_d = ST_IDLE;
    end
    // A pop overrides the return to IDLE, so bursts chain without a bubble.
    if (pop) begin
      state_d = ST_ISSUE;
      id_d    = bus.cf_id;
      user_d  = bus.cf_user;
      cur_d   = bus.cf_addr;
      first_d = 1'b1;
      err_d   = (burst_e'(bus.cf_burst) != BURST_INCR);
      rem_d   = err_d ? 16'd0 : burst_bytes(bus.cf_addr[6:0], bus.cf_len, bus.cf_size);
    end
  end

  // Rejected bursts carry rem=0, which the calculator turns into a zero-byte last piece.
  always_comb begin
    issue        = (state_q == ST_ISSUE);
    hs           = issue & bus.sp_ready;
    pop          = rst_n & ~bus.cf_empty & (~issue | (hs & calc_last));
    bus.cf_rd_en = pop;
    bus.sp_valid = issue;
    bus.sp_id    = issue ? id_q   : '0;
    bus.sp_addr  = issue ? cur_q  : '0;
    bus.sp_user  = issue ? user_q : '0;
    bus.sp_bytes = issue ? calc_bytes : '0;
    bus.sp_first = issue & first_q;
    bus.sp_last  = issue & calc_last;
    bus.sp_err   = issue & err_q;
  end

`ifdef AXI_SLAVE_SPLITTER_STATS_EN
  logic [31:0] stat_bursts_q, stat_bursts_d;
  logic [31:0] stat_pieces_q, stat_pieces_d;

  always_comb begin
    stat_bursts_d = stat_bursts_q + {31'd0, pop};
    stat_pieces_d = stat_pieces_q + {31'd0, hs};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bursts_q <= '0;
      stat_pieces_q <= '0;
    end else begin
      stat_bursts_q <= stat_bursts_d;
      stat_pieces_q <= stat_pieces_d;
    end
  end

  assign stat_bursts = stat_bursts_q;
  assign stat_pieces = stat_pieces_q;
`endif

endmodule

// File: tb/tb_axi_slave_cmd_splitter.sv
// Scoreboard bench for axi_slave_cmd_splitter: a queue-modelled FIFO feeds
// directed bursts, expected pieces are queued up front and checked by a monitor.
module tb_axi_slave_cmd_splitter;

  typedef struct {
    logic [2:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [8:0]  user;
  } burst_t;

  typedef struct packed {
    logic [2:0]  id;
    logic [63:0] addr;
    logic [7:0]  bytes;
    logic [8:0]  user;
    logic        first;
    logic        last;
    logic        err;
  } piece_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_seen = 1'b0;
  logic rand_ready = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  burst_t fifo[$];
  piece_t exp_q[$];

  axi_slave_cmd_splitter_if #(.IDW(3), .CTXW(9), .CHUNK_LOG2(7)) bus ();

`ifdef AXI_SLAVE_SPLITTER_STATS_EN
  logic [31:0] stat_bursts, stat_pieces;
`endif

  axi_slave_cmd_splitter #(.IDW(3), .CTXW(9), .CHUNK_LOG2(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef AXI_SLAVE_SPLITTER_STATS_EN
    ,
    .stat_bursts (stat_bursts),
    .stat_pieces (stat_pieces)
`endif
  );

  always #5 clk = ~clk;

  // The pop request seen mid-cycle is what the DUT commits at the next edge.
  always @(negedge clk) rd_seen <= bus.cf_rd_en;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic drive_head();
    if (fifo.size() != 0) begin
      bus.cf_empty = 1'b0;
      bus.cf_id    = fifo[0].id;
      bus.cf_addr  = fifo[0].addr;
      bus.cf_len   = fifo[0].len;
      bus.cf_size  = fifo[0].size;
      bus.cf_burst = fifo[0].burst;
      bus.cf_user  = fifo[0].user;
    end else begin
      bus.cf_empty = 1'b1;
      bus.cf_id    = '0;
      bus.cf_addr  = '0;
      bus.cf_len   = '0;
      bus.cf_size  = '0;
      bus.cf_burst = '0;
      bus.cf_user  = '0;
    end
  endtask

  task automatic add(input logic [2:0] id, input logic [63:0] addr, input logic [7:0] len,
                     input logic [2:0] size, input logic [1:0] burst, input logic [8:0] user);
    burst_t b;
    b.id = id; b.addr = addr; b.len = len; b.size = size; b.burst = burst; b.user = user;
    fifo.push_back(b);
    drive_head();
  endtask

  task automatic expect_piece(input logic [2:0] id, input logic [63:0] addr, input logic [7:0] bytes,
                              input logic [8:0] user, input logic first, input logic last,
                              input logic err);
    piece_t p;
    p.id = id; p.addr = addr; p.bytes = bytes; p.user = user;
    p.first = first; p.last = last; p.err = err;
    exp_q.push_back(p);
  endtask

  // Advance to 1 time unit after the next rising edge and update the FIFO model.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rd_seen) begin
      if (fifo.size() == 0) check("pop_of_empty_fifo", 1, 0);
      else fifo.delete(0);
    end
    bus.sp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_head();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check({name, "_done"}, 128'(exp_q.size()), 0);
    cycle();
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.cf_rd_en, bus.sp_valid, bus.sp_id, bus.sp_addr, bus.sp_bytes,
                 bus.sp_user, bus.sp_first, bus.sp_last, bus.sp_err}, 0);
`ifdef AXI_SLAVE_SPLITTER_STATS_EN
    check({name, "_stats"}, {stat_bursts, stat_pieces}, 0);
`endif
  endtask

  // Monitor: compares each accepted piece and checks outputs hold while stalled.
  initial begin
    piece_t cur, prev, e;
    logic   prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur.id = bus.sp_id; cur.addr = bus.sp_addr; cur.bytes = bus.sp_bytes;
      cur.user = bus.sp_user; cur.first = bus.sp_first; cur.last = bus.sp_last;
      cur.err = bus.sp_err;
      if (rst_n && prev_stall) check("hold_while_stalled", {bus.sp_valid, cur}, {1'b1, prev});
      prev_stall = rst_n && bus.sp_valid && !bus.sp_ready;
      prev = cur;
      if (rst_n && bus.sp_valid && bus.sp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_piece", 128'(cur), 0);
        end else begin
          e = exp_q.pop_front();
          check("piece", 128'(cur), 128'(e));
          check("pop_with_last", 128'(bus.cf_rd_en), 128'(e.last & !bus.cf_empty));
        end
      end
    end
  end

  initial begin
    int hs_cnt, bubbles, n;
    bus.sp_ready = 1'b1;
    drive_head();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Aligned 128B burst: one pop, valid one cycle later, single piece.
    add(3'd1, 64'h1000, 8'd7, 3'd4, 2'b01, 9'h011);
    expect_piece(3'd1, 64'h1000, 8'd128, 9'h011, 1, 1, 0);
    @(negedge clk);
    check("pop_cycle_rd_en", 128'(bus.cf_rd_en), 1);
    check("pop_cycle_valid", 128'(bus.sp_valid), 0);
    cycle();
    @(negedge clk);
    check("issue_cycle_rd_en", 128'(bus.cf_rd_en), 0);
    check("issue_cycle_valid", 128'(bus.sp_valid), 1);
    wait_done("aligned", 20);

    // 256B from 0x1040: 64 + 128 + 64.
    add(3'd2, 64'h1040, 8'd15, 3'd4, 2'b01, 9'h122);
    expect_piece(3'd2, 64'h1040, 8'd64,  9'h122, 1, 0, 0);
    expect_piece(3'd2, 64'h1080, 8'd128, 9'h122, 0, 0, 0);
    expect_piece(3'd2, 64'h1100, 8'd64,  9'h122, 0, 1, 0);
    wait_done("three_piece", 20);

    // Unaligned single byte, then a 4B burst straddling a chunk boundary.
    add(3'd3, 64'h2003, 8'd0, 3'd2, 2'b01, 9'h033);
    expect_piece(3'd3, 64'h2003, 8'd1, 9'h033, 1, 1, 0);
    wait_done("one_byte", 20);
    add(3'd4, 64'h20FE, 8'd3, 3'd0, 2'b01, 9'h144);
    expect_piece(3'd4, 64'h20FE, 8'd2, 9'h144, 1, 0, 0);
    expect_piece(3'd4, 64'h2100, 8'd2, 9'h144, 0, 1, 0);
    wait_done("straddle", 20);

    // Three preloaded bursts, ready held high: five pieces with no bubble.
    add(3'd5, 64'h3000, 8'd3,  3'd3, 2'b01, 9'h055);
    add(3'd6, 64'h3070, 8'd7,  3'd3, 2'b01, 9'h066);
    add(3'd7, 64'h4000, 8'd31, 3'd3, 2'b01, 9'h177);
    expect_piece(3'd5, 64'h3000, 8'd32,  9'h055, 1, 1, 0);
    expect_piece(3'd6, 64'h3070, 8'd16,  9'h066, 1, 0, 0);
    expect_piece(3'd6, 64'h3080, 8'd48,  9'h066, 0, 1, 0);
    expect_piece(3'd7, 64'h4000, 8'd128, 9'h177, 1, 0, 0);
    expect_piece(3'd7, 64'h4080, 8'd128, 9'h177, 0, 1, 0);
    hs_cnt = 0;
    bubbles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sp_valid) hs_cnt++;
      else if (hs_cnt > 0) bubbles++;
      if (hs_cnt == 5) break;
      cycle();
    end
    check("b2b_pieces", 128'(hs_cnt), 5);
    check("b2b_bubbles", 128'(bubbles), 0);
    wait_done("back_to_back", 20);

    // WRAP is rejected as one zero-byte error piece; the next INCR is normal.
    add(3'd1, 64'h5010, 8'd3, 3'd2, 2'b10, 9'h0AA);
    add(3'd2, 64'h5000, 8'd1, 3'd2, 2'b01, 9'h0BB);
    expect_piece(3'd1, 64'h5010, 8'd0, 9'h0AA, 1, 1, 1);
    expect_piece(3'd2, 64'h5000, 8'd8, 9'h0BB, 1, 1, 0);
    wait_done("wrap_reject", 20);

    // Random backpressure over a full burst.
    rand_ready = 1'b1;
    add(3'd3, 64'h6000, 8'd63, 3'd2, 2'b01, 9'h1C3);
    expect_piece(3'd3, 64'h6000, 8'd128, 9'h1C3, 1, 0, 0);
    expect_piece(3'd3, 64'h6080, 8'd128, 9'h1C3, 0, 1, 0);
    wait_done("backpressure", 200);

    // Reset in the middle of a five-piece burst; the queued burst runs afterwards.
    add(3'd4, 64'h7010, 8'd31, 3'd4, 2'b01, 9'h0D4);
    add(3'd5, 64'h8000, 8'd0,  3'd0, 2'b01, 9'h0E5);
    expect_piece(3'd4, 64'h7010, 8'd112, 9'h0D4, 1, 0, 0);
    expect_piece(3'd4, 64'h7080, 8'd128, 9'h0D4, 0, 0, 0);
    expect_piece(3'd4, 64'h7100, 8'd128, 9'h0D4, 0, 0, 0);
    expect_piece(3'd4, 64'h7180, 8'd128, 9'h0D4, 0, 0, 0);
    expect_piece(3'd4, 64'h7200, 8'd16,  9'h0D4, 0, 1, 0);
    expect_piece(3'd5, 64'h8000, 8'd1,   9'h0E5, 1, 1, 0);
    n = 0;
    while (exp_q.size() > 4 && n < 200) begin
      cycle();
      n++;
    end
    check("reached_mid_burst", 128'(exp_q.size()), 4);
    rst_n = 1'b0;
    exp_q.delete();
    expect_piece(3'd5, 64'h8000, 8'd1, 9'h0E5, 1, 1, 0);
    @(negedge clk);
    check_reset_outputs("mid_burst_reset");
    check("head_after_reset", fifo[0].addr, 64'h8000);
    cycle();
    @(negedge clk);
    check_reset_outputs("reset_held");
    cycle();
    rst_n = 1'b1;
    wait_done("after_reset", 200);
    check("fifo_drained", 128'(fifo.size()), 0);
`ifdef AXI_SLAVE_SPLITTER_STATS_EN
    check("stat_bursts_after_reset", 128'(stat_bursts), 1);
    check("stat_pieces_after_reset", 128'(stat_pieces), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
